// File: rtl/serial_pkg.sv
// Shared types and defaults for the bit-serial adder.
// Imported by the top level and by the testbench.
package serial_pkg;

  localparam int DEF_WIDTH = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

endpackage

// File: rtl/full_adder.sv
// Gate-level full adder cell.
// Two half-adder stages whose carries are merged by an OR.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic h1_s;
  logic h1_c;
  logic h2_c;

  assign h1_s = a ^ b;
  assign h1_c = a & b;

  assign s    = h1_s ^ cin;
  assign h2_c = h1_s & cin;

  assign cout = h1_c | h2_c;

endmodule

// File: rtl/serial_adder.sv
// Bit-serial unsigned adder: one full-adder cell, LSB first.
// Produces {cout,sum} = a + b after WIDTH shift cycles.
module serial_adder
  import serial_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] s_sr_q, s_sr_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             done_q, done_d;
  logic             s_bit;
  logic             c_bit;

  full_adder u_fa (
    .a    (a_sr_q[0]),
    .b    (b_sr_q[0]),
    .cin  (carry_q),
    .s    (s_bit),
    .cout (c_bit)
  );

  always_comb begin
    state_d = state_q;
    a_sr_d  = a_sr_q;
    b_sr_d  = b_sr_q;
    s_sr_d  = s_sr_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SHIFT;
          a_sr_d  = a;
          b_sr_d  = b;
          s_sr_d  = '0;
          carry_d = 1'b0;
          cnt_d   = '0;
        end
      end
      SHIFT: begin
        carry_d = c_bit;
        s_sr_d  = {s_bit, s_sr_q[WIDTH-1:1]};
        a_sr_d  = {1'b0, a_sr_q[WIDTH-1:1]};
        b_sr_d  = {1'b0, b_sr_q[WIDTH-1:1]};
        cnt_d   = cnt_q + 1'b1;
        // Last bit: publish the result including this cycle's sum bit
        if (cnt_q == LAST) begin
          state_d = IDLE;
          sum_d   = {s_bit, s_sr_q[WIDTH-1:1]};
          cout_d  = c_bit;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_sr_q  <= '0;
      b_sr_q  <= '0;
      s_sr_q  <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sr_q  <= a_sr_d;
      b_sr_q  <= b_sr_d;
      s_sr_q  <= s_sr_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      done_q  <= done_d;
    end
  end

  assign busy = (state_q == SHIFT);
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder at WIDTH=8 and WIDTH=2.
// Results and timing compared against plain a+b arithmetic.
module tb_serial_adder;

  logic       clk;
  logic       rst_n;

  logic       start8;
  logic [7:0] a8, b8;
  logic       busy8, done8, cout8;
  logic [7:0] sum8;

  logic       start2;
  logic [1:0] a2, b2;
  logic       busy2, done2, cout2;
  logic [1:0] sum2;

  int         checks;
  int         errors;
  logic [8:0] prev8;

  serial_adder #(.WIDTH(8)) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start8),
    .a     (a8),
    .b     (b8),
    .busy  (busy8),
    .done  (done8),
    .sum   (sum8),
    .cout  (cout8)
  );

  serial_adder #(.WIDTH(2)) dut2 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start2),
    .a     (a2),
    .b     (b2),
    .busy  (busy2),
    .done  (done2),
    .sum   (sum2),
    .cout  (cout2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One WIDTH=8 operation; pulse_at>=0 injects a start while busy
  task automatic op8(input logic [7:0] a,
                     input logic [7:0] b,
                     input int pulse_at);
    logic [8:0] exp;
    int n;
    exp = {1'b0, a} + {1'b0, b};
    a8 = a;
    b8 = b;
    start8 = 1'b1;
    tick();
    start8 = 1'b0;
    a8 = 8'($urandom);
    b8 = 8'($urandom);
    n = 0;
    while (!done8 && n < 20) begin
      check("busy8", 32'(busy8), 32'd1);
      check("hold8", 32'({cout8, sum8}), 32'(prev8));
      if (n == pulse_at) begin
        start8 = 1'b1;
        a8 = 8'h01;
        b8 = 8'h01;
      end else begin
        start8 = 1'b0;
      end
      tick();
      n++;
    end
    start8 = 1'b0;
    check("lat8", 32'(n), 32'd8);
    check("res8", 32'({cout8, sum8}), 32'(exp));
    check("busy_at_done8", 32'(busy8), 32'd0);
    prev8 = exp;
    tick();
    check("pulse8", 32'(done8), 32'd0);
    check("idle8", 32'(busy8), 32'd0);
  endtask

  initial begin
    int n;
    int dones;
    logic [2:0] e2;
    checks = 0;
    errors = 0;
    prev8  = '0;
    start8 = 1'b0;
    a8 = '0;
    b8 = '0;
    start2 = 1'b0;
    a2 = '0;
    b2 = '0;
    rst_n = 1'b0;
    #12;
    check("rst_busy", 32'(busy8), 32'd0);
    check("rst_done", 32'(done8), 32'd0);
    check("rst_res", 32'({cout8, sum8}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    op8(8'h00, 8'h00, -1);
    op8(8'h5A, 8'h25, -1);
    op8(8'hFF, 8'h01, -1);
    op8(8'hFF, 8'hFF, -1);
    op8(8'h10, 8'h20, 3);

    // Reset in the middle of an operation
    a8 = 8'h33;
    b8 = 8'h44;
    start8 = 1'b1;
    tick();
    start8 = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", 32'(busy8), 32'd0);
    check("mid_rst_done", 32'(done8), 32'd0);
    check("mid_rst_res", 32'({cout8, sum8}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    prev8 = '0;
    dones = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (done8) dones++;
    end
    check("no_done_after_rst", 32'(dones), 32'd0);

    // Back-to-back with start held high
    a8 = 8'h01;
    b8 = 8'h02;
    start8 = 1'b1;
    tick();
    n = 0;
    while (!done8 && n < 20) begin
      tick();
      n++;
    end
    check("b2b_lat1", 32'(n), 32'd8);
    check("b2b_res1", 32'({cout8, sum8}), 32'h003);
    a8 = 8'h80;
    b8 = 8'h80;
    n = 0;
    do begin
      tick();
      n++;
    end while (!done8 && n < 30);
    start8 = 1'b0;
    check("b2b_gap", 32'(n), 32'd9);
    check("b2b_res2", 32'({cout8, sum8}), 32'h100);
    prev8 = 9'h100;
    tick();
    check("b2b_idle", 32'(busy8), 32'd0);

    for (int i = 0; i < 1000; i++) begin
      op8(8'($urandom), 8'($urandom), -1);
    end

    for (int i = 0; i < 1000; i++) begin
      a2 = 2'($urandom);
      b2 = 2'($urandom);
      e2 = {1'b0, a2} + {1'b0, b2};
      start2 = 1'b1;
      tick();
      start2 = 1'b0;
      a2 = 2'($urandom);
      b2 = 2'($urandom);
      n = 0;
      while (!done2 && n < 10) begin
        tick();
        n++;
      end
      check("lat2", 32'(n), 32'd2);
      check("res2", 32'({cout2, sum2}), 32'(e2));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
# serial_adder

Bit-serial unsigned adder, the addition counterpart to our half-subtractor cells. It accepts two WIDTH-bit operands on a start pulse and adds them LSB-first through one full-adder cell and a carry flip-flop, one bit per clock. It presents the registered sum and carry-out with a one-cycle done pulse. It serves area-constrained datapaths where WIDTH cycles of latency is acceptable in exchange for a single adder cell.

## Interface
- WIDTH, 8: operand and sum width in bits; legal range 2–32.
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  request; sampled only when idle
- a  input  WIDTH  augend; captured on accepted start
- b  input  WIDTH  addend; captured on accepted start
- busy  output  1  high while an addition is in progress
- done  output  1  one-cycle pulse; sum/cout valid from this cycle
- sum  output  WIDTH  registered result, held until next completion
- cout  output  1  registered carry-out of bit WIDTH-1

One clock; reset is asynchronous and active-low. Ports are named clk and rst_n.

## Operation
- FSM states:
  - IDLE, encoding 0: waiting for a request.
  - SHIFT, encoding 1: addition in progress.
- IDLE to SHIFT:
  - Taken when start=1 at a clock edge.
  - Loads a_sr←a, b_sr←b, s_sr←0, carry←0, cnt←0.
- SHIFT cycle actions:
  - The full adder computes s_bit and c_bit from a_sr[0], b_sr[0] and carry.
  - carry←c_bit.
  - s_sr←{s_bit, s_sr[WIDTH-1:1]}.
  - a_sr and b_sr shift right by one, filling with 0.
  - cnt←cnt+1.
- SHIFT to IDLE: taken on the cycle where cnt==WIDTH-1. On that edge:
  - sum←final s_sr value, including the current bit.
  - cout←c_bit.
  - done←1.
- done is a registered pulse, high for exactly one cycle, the first IDLE cycle after completion.
- busy = (state==SHIFT), decoded directly from the state register.
- start while busy is ignored; no queuing, no error flag.
- start in the done cycle is accepted because the state is IDLE, which allows back-to-back operation.
- sum and cout change only on completion. They hold their previous values throughout busy.
- Arithmetic: {cout,sum} = a + b, modulo 2^(WIDTH+1); no overflow indication beyond cout.
- cnt width is clog2(WIDTH); it never wraps within an operation.

## Timing
- Reset (asynchronous assert, synchronous deassert assumed upstream):
  - state=IDLE, busy=0, done=0, sum=0, cout=0.
  - All internal shift registers, carry and cnt are 0.
- Reset mid-operation aborts immediately. Outputs return to their reset values, and no done pulse follows.
- Latency: start sampled at edge k gives busy=1 for cycles k+1…k+WIDTH.
- done=1 and the new sum/cout are visible in cycle k+WIDTH+1.
- Throughput: one result per WIDTH+1 cycles with start held or re-pulsed at each done.
- a and b need only be valid at the accepting edge. Later changes have no effect.

## Structure
- Shared package serial_pkg holds:
  - the state typedef (IDLE, SHIFT);
  - the default WIDTH constant.
- One sub-module, full_adder, with ports a, b, cin, s, cout:
  - built structurally from two half-adder stages plus an OR, matching our gate-level cell style;
  - instantiated once.
- The top level holds the FSM, counter, shift registers, carry flop and output registers.

## Test plan
- Reset, then a=0x00, b=0x00, start pulse: busy for 8 cycles, then done with sum=0x00, cout=0.
- a=0x5A, b=0x25: done at cycle k+9 with sum=0x7F, cout=0; sum holds its old value while busy.
- a=0xFF, b=0x01, giving full carry ripple: sum=0x00, cout=1. Then a=0xFF, b=0xFF: sum=0xFE, cout=1.
- Start 0x10+0x20, pulse start with a=0x01, b=0x01 in cycle k+4: the second request is ignored. Result sum=0x30 with exactly one done pulse.
- Start 0x33+0x44, assert rst_n=0 in cycle k+3: busy, done, sum and cout are 0 immediately. Without a new start, no done ever appears.
- Back-to-back, with start held high:
  - 0x01+0x02, then 0x80+0x80 accepted at the first done cycle.
  - Second done at 9 cycles after the first, with sum=0x00, cout=1.
  - Randomized 1000-pair run against the reference model {cout,sum}=a+b for WIDTH=8 and WIDTH=2.
